// File: rtl/wish_unpack_pkg.sv
// Shared helpers for the Wishbone width converters (packer/unpacker).
// Index widths and beat-to-slice mapping live here so both sides agree.
package wish_unpack_pkg;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int ctr_width(input int max_out);
        return $clog2(max_out + 1);
    endfunction

    // Maps a beat number to the slice of the wide word it carries.
    function automatic int slice_sel(input int idx, input int n, input bit little);
        return little ? idx : (n - 1 - idx);
    endfunction

endpackage

// File: rtl/wish_outstanding_ctr.sv
// Up/down counter of issued-but-unacked beats, saturating at 0 and MAX.
// Exposes a limit flag and a nonzero flag for strobe and cycle gating.
module wish_outstanding_ctr #(
    parameter int MAX = 4,
    parameter int W   = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic inc,
    input  logic dec,
    output logic at_limit,
    output logic nonzero
);

    logic [W-1:0] cnt;
    logic         inc_ok;
    logic         dec_ok;

    assign nonzero  = (cnt != '0);
    assign at_limit = (cnt == W'(MAX));
    assign inc_ok   = inc & ~at_limit;
    assign dec_ok   = dec & nonzero;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (inc_ok & ~dec_ok) begin
            cnt <= cnt + 1'b1;
        end else if (dec_ok & ~inc_ok) begin
            cnt <= cnt - 1'b1;
        end
    end

endmodule

// File: rtl/wish_unpack.sv
// Wishbone B4 pipelined unpacker: one wide word in, NUM_PACK narrow beats out.
// The stall drops on the last beat so consecutive words stream without a bubble.
module wish_unpack
    import wish_unpack_pkg::*;
#(
    parameter int DATA_WIDTH      = 8,
    parameter int NUM_PACK        = 4,
    parameter int TGC_WIDTH       = 2,
    parameter int LITTLE_ENDIAN   = 0,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           s_stb_i,
    input  logic                           s_cyc_i,
    input  logic [DATA_WIDTH*NUM_PACK-1:0] s_dat_i,
    input  logic [TGC_WIDTH-1:0]           s_tgc_i,
    output logic                           s_ack_o,
    output logic                           s_stall_o,
    output logic                           d_stb_o,
    output logic                           d_cyc_o,
    output logic [DATA_WIDTH-1:0]          d_dat_o,
    output logic [TGC_WIDTH-1:0]           d_tgc_o,
    input  logic                           d_ack_i,
    input  logic                           d_stall_i
);

    localparam int IW = idx_width(NUM_PACK);
    localparam int CW = ctr_width(MAX_OUTSTANDING);
    localparam int WW = DATA_WIDTH * NUM_PACK;
    localparam logic [IW-1:0] LAST = IW'(NUM_PACK - 1);

    logic                 valid;
    logic [WW-1:0]        hold;
    logic [TGC_WIDTH-1:0] tag;
    logic [IW-1:0]        idx;
    logic [IW-1:0]        slot;
    logic                 ack_q;
    logic                 at_limit;
    logic                 busy;
    logic                 issue;
    logic                 last;
    logic                 accept;

    assign d_stb_o   = valid & ~at_limit;
    assign issue     = d_stb_o & ~d_stall_i;
    assign last      = issue & (idx == LAST);
    assign s_stall_o = valid & ~last;
    assign accept    = s_cyc_i & s_stb_i & ~s_stall_o;
    assign s_ack_o   = ack_q;
    assign d_cyc_o   = valid | busy;
    assign d_tgc_o   = tag;

    always_comb begin
        slot    = IW'(slice_sel(int'(idx), NUM_PACK, LITTLE_ENDIAN != 0));
        d_dat_o = hold[slot*DATA_WIDTH +: DATA_WIDTH];
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            valid <= 1'b0;
            hold  <= '0;
            tag   <= '0;
            idx   <= '0;
            ack_q <= 1'b0;
        end else begin
            ack_q <= accept;
            if (accept) begin
                valid <= 1'b1;
                hold  <= s_dat_i;
                tag   <= s_tgc_i;
                idx   <= '0;
            end else if (last) begin
                valid <= 1'b0;
            end else if (issue) begin
                idx <= idx + 1'b1;
            end
        end
    end

    wish_outstanding_ctr #(
        .MAX (MAX_OUTSTANDING),
        .W   (CW)
    ) u_ctr (
        .clk      (clk_i),
        .rst_n    (rst_i),
        .inc      (issue),
        .dec      (d_ack_i),
        .at_limit (at_limit),
        .nonzero  (busy)
    );

endmodule

// File: doc/wish_unpack.md
Name: wish_unpack

Overview:
- Width-converting Wishbone (pipelined, B4) streaming bridge.
- Accepts one wide word of DATA_WIDTH*NUM_PACK bits on the slave side and emits NUM_PACK narrow DATA_WIDTH beats on the master side, in a configurable slice order.
- It is the inverse of the team's packer and sits on the downstream path, where a wide datapath feeds a narrow consumer.
- The cycle tag is carried with every beat.

Parameters:
- DATA_WIDTH, 8: width of one output beat.
- NUM_PACK, 4: beats per input word (>=2).
- TGC_WIDTH, 2: cycle-tag width.
- LITTLE_ENDIAN, 0: 1 = first beat is slice [DATA_WIDTH-1:0]; 0 = first beat is the most-significant slice.
- MAX_OUTSTANDING, 4: maximum master-side beats issued but not yet acked (>=1).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset; asynchronous, active-low.
- s_stb_i  in  1  slave strobe.
- s_cyc_i  in  1  slave cycle.
- s_dat_i  in  DATA_WIDTH*NUM_PACK  wide input word.
- s_tgc_i  in  TGC_WIDTH  input cycle tag.
- s_ack_o  out  1  slave acknowledge.
- s_stall_o  out  1  slave stall.
- d_stb_o  out  1  master strobe.
- d_cyc_o  out  1  master cycle.
- d_dat_o  out  DATA_WIDTH  current beat.
- d_tgc_o  out  TGC_WIDTH  tag of the word being unpacked.
- d_ack_i  in  1  master acknowledge.
- d_stall_i  in  1  master stall.

Behaviour:
- Reset: while rst_i is low, all outputs are 0: s_ack_o, s_stall_o, d_stb_o, d_cyc_o, d_dat_o, d_tgc_o. Internal state (holding valid, beat index, outstanding count) is also cleared. Reset asserted mid-word discards the word; no partial beats are emitted after release.
- Slave accept: a word is accepted when s_cyc_i & s_stb_i & !s_stall_o. On accept, s_dat_i and s_tgc_i are latched into a single holding register and the index is set to 0.
- Slave acknowledge: s_ack_o is registered and pulses exactly one cycle after each accept. Acks are never issued without a prior accept.
- s_stall_o:
  - Asserted when the holding register is valid, except in the cycle in which its last beat (index NUM_PACK-1) issues.
  - This gives back-to-back words with no bubble: steady-state throughput is one beat per cycle.
- Master issue:
  - d_stb_o = holding valid & (outstanding < MAX_OUTSTANDING).
  - A beat issues when d_stb_o & !d_stall_i; the index then increments.
  - After beat NUM_PACK-1 issues, the holding register is invalid unless a new word is accepted in the same cycle.
- Beat selection:
  - d_dat_o = slice[index] when LITTLE_ENDIAN=1, slice[NUM_PACK-1-index] when 0.
  - Driven combinationally from the holding register and index, and stable while stalled.
  - d_tgc_o = latched tag, identical on all beats of a word.
- Outstanding counter:
  - +1 on issue, -1 on d_ack_i, unchanged when both occur in the same cycle.
  - Width is clog2(MAX_OUTSTANDING+1).
  - d_ack_i with outstanding==0 is ignored; the counter saturates at 0.
- d_cyc_o = holding valid | (outstanding != 0). It drops the cycle after the final ack when no word is pending.
- s_cyc_i deassertion: new accepts stop, but an already-accepted word drains completely. s_stb_i without s_cyc_i is ignored.
- Latency: first beat visible on d_stb_o one cycle after accept. A word occupies NUM_PACK issue cycles when d_stall_i=0 and MAX_OUTSTANDING is not reached.

Decomposition:
- Shared package: beat-index width function (clog2), outstanding-counter width function, and the slice-select function shared with the packer.
- Natural sub-module: wish_outstanding_ctr, an up/down saturating counter with a limit flag and a nonzero flag, reusable by the packer.

Test Plan:
- Big-endian basic (LITTLE_ENDIAN=0, DATA_WIDTH=8, NUM_PACK=4), accept 0x00010203 with tag 2'b01, d_ack_i tied 1, d_stall_i=0 -> beats 0x00,0x01,0x02,0x03 on consecutive cycles, all with d_tgc_o=01; s_ack_o pulses once, one cycle after accept.
- Little-endian (LITTLE_ENDIAN=1), same word -> beats 0x03,0x02,0x01,0x00.
- Back-to-back: present 0x00010203 then 0x04050607 continuously -> 8 beats 0x00..0x07 with no gap; s_stall_o high on 3 of every 4 cycles.
- Backpressure: d_stall_i high for 3 cycles during beat 1 -> d_dat_o holds 0x01, index does not advance, and s_stall_o stays high.
- Outstanding limit (MAX_OUTSTANDING=2, d_ack_i held 0) -> exactly 2 beats issue, then d_stb_o=0 with d_cyc_o=1; a single d_ack_i pulse -> one more beat issues. After all acks return, d_cyc_o falls.
- Async reset: assert rst_i low between clock edges mid-word -> all outputs 0 immediately; after release, the next accepted word starts at beat 0 with outstanding=0.
